multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32I core. It sequences each instruction through fetch, decode,

---
 rtl/multicycle_controller_pkg.sv | 21 ++
 rtl/multicycle_controller_branch_resolver.sv | 16 +
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// riscv_ctrl_pkg: opcodes, 4-bit state encodings and datapath select encodings for the multicycle controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_LUI, S_AUIPC, S_TRAP
  } state_t;
  typedef enum logic [1:0] {RS_ALUOUT, RS_DATA, RS_ALURES, RS_IMM} result_src_t;
  typedef enum logic [1:0] {SA_PC, SA_OLDPC, SA_RD1} src_a_t;
  typedef enum logic [1:0] {SB_RD2, SB_IMM, SB_FOUR} src_b_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
endpackage

// File: rtl/multicycle_controller_branch_resolver.sv
// branch_resolver: funct3 + ALU flags (Zero, ALUR31, ALU_Carry) -> taken, bad_funct3 for 010/011
module branch_resolver (
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       ALU_Carry,
  output logic       taken,
  output logic       bad_funct3
);
  logic cond;
  always_comb begin
    cond = funct3[2] ? (funct3[1] ? ALU_Carry : ALUR31) : Zero;
    taken = cond ^ funct3[0];
    bad_funct3 = funct3[2:1] == 2'b01;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM; op/funct3/ALU flags/mem_ready in, datapath selects, strobes, trap/bus_err, state_dbg out
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN     = 1'b1,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit HAS_UPPER       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       ALU_Carry,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       trap,
  output logic       bus_err,
  output logic [3:0] state_dbg
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_t state, nxt, ill;
  logic [CW-1:0] cnt;
  logic trap_q, bus_err_q, ready, taken, bad_funct3, timeout, waiting;
  logic pc_write, mem_write, ir_write, reg_write, req;
  branch_resolver u_br (
    .funct3(funct3), .Zero(Zero), .ALUR31(ALUR31), .ALU_Carry(ALU_Carry),
    .taken(taken), .bad_funct3(bad_funct3)
  );
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  // The cycle after the counter reaches the limit is a dead cycle: strobes off, flags visible, heading to TRAP.
  assign timeout = TIMEOUT_CYCLES > 0 && cnt == CW'(TIMEOUT_CYCLES);
  assign waiting = TIMEOUT_CYCLES > 0 && req && !ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_FETCH;
      cnt <= '0;
      trap_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : cnt + CW'(waiting);
      trap_q <= trap_q | (nxt == S_TRAP);
      bus_err_q <= bus_err_q | timeout;
    end
  always_comb begin
    nxt = state;
    ill = S_FETCH;
    if (TRAP_ON_ILLEGAL) ill = S_TRAP;
    pc_write = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    req = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = RS_ALUOUT;
    ALUSrcA = SA_PC;
    ALUSrcB = SB_RD2;
    ALUOp = ALU_ADD;
    ImmSrc = IMM_I;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        ALUSrcB = SB_FOUR;
        ResultSrc = RS_ALURES;
        ir_write = ready;
        pc_write = ready;
        if (ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_IMM;
        ImmSrc = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_R:      nxt = S_EXECR;
          OP_I:      nxt = S_EXECI;
          OP_BRANCH: nxt = S_BRANCH;
          OP_JAL:    nxt = S_JAL;
          OP_JALR:   nxt = S_JALR;
          OP_LUI:    if (HAS_UPPER) nxt = S_LUI; else nxt = ill;
          OP_AUIPC:  if (HAS_UPPER) nxt = S_AUIPC; else nxt = ill;
          default:   nxt = ill;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_IMM;
        ImmSrc = op == OP_STORE ? IMM_S : IMM_I;
        if (op == OP_STORE) nxt = S_MEMWRITE; else nxt = S_MEMREAD;
      end
      S_MEMREAD: begin
        req = 1'b1;
        AdrSrc = 1'b1;
        if (ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RS_DATA;
        reg_write = 1'b1;
        nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        req = 1'b1;
        mem_write = 1'b1;
        AdrSrc = 1'b1;
        if (ready) nxt = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SA_RD1;
        ALUOp = ALU_FUNCT;
        nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_IMM;
        ALUOp = ALU_FUNCT;
        nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SA_RD1;
        ALUOp = ALU_SUB;
        pc_write = taken & ~bad_funct3;
        if (bad_funct3) nxt = ill; else nxt = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_FOUR;
        pc_write = 1'b1;
        nxt = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_IMM;
        nxt = S_JALRPC;
      end
      S_JALRPC: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_FOUR;
        pc_write = 1'b1;
        nxt = S_ALUWB;
      end
      S_LUI: begin
        ImmSrc = IMM_U;
        ResultSrc = RS_IMM;
        reg_write = 1'b1;
        nxt = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_IMM;
        ImmSrc = IMM_U;
        nxt = S_ALUWB;
      end
      default: nxt = S_TRAP;
    endcase
    if (timeout) begin
      nxt = S_TRAP;
      pc_write = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      req = 1'b0;
    end
  end
  // Strobes drop combinationally while reset is held, not just at the next edge.
  assign PCWrite = pc_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite = ir_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign mem_req = req & ~reset;
  assign trap = trap_q | timeout;
  assign bus_err = bus_err_q | timeout;
  assign state_dbg = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed bench with a path-level model of the multicycle controller
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;
  typedef struct packed {
    logic pcw, adr, req, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop;
    logic [2:0] imm;
    logic trap, berr;
    logic [3:0] st;
  } vec_t;
  typedef state_t sq_t[$];
  typedef struct {logic [2:0] f; logic [31:0] a; logic [31:0] b; logic t;} br_t;
  logic clk = 1'b0;
  logic [1:0] rst, zero, r31, cy, rdy, chk;
  logic [6:0] op [2];
  logic [2:0] f3 [2];
  vec_t act [2];
  vec_t expv [2];
  vec_t obs[$];
  string cur_tag = "";
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : d
    logic pcw, adr, req, mw, irw, rw, tr, be;
    logic [1:0] rs, sa, sb, ao;
    logic [2:0] im;
    logic [3:0] st;
    multicycle_controller #(
      .MEM_WAIT_EN(1'b1), .TIMEOUT_CYCLES(g == 0 ? 0 : 4),
      .TRAP_ON_ILLEGAL(g == 0), .HAS_UPPER(g == 0)
    ) u (
      .clk(clk), .reset(rst[g]), .op(op[g]), .funct3(f3[g]), .Zero(zero[g]), .ALUR31(r31[g]),
      .ALU_Carry(cy[g]), .mem_ready(rdy[g]), .PCWrite(pcw), .AdrSrc(adr), .mem_req(req),
      .MemWrite(mw), .IRWrite(irw), .RegWrite(rw), .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb),
      .ALUOp(ao), .ImmSrc(im), .trap(tr), .bus_err(be), .state_dbg(st)
    );
    assign act[g] = {pcw, adr, req, mw, irw, rw, rs, sa, sb, ao, im, tr, be, st};
  end
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (chk[k]) begin
        nvec++;
        if (act[k] !== expv[k]) begin
          nerr++;
          $display("FAIL dut%0d %s: got %h want %h (state got %0d want %0d)", k, cur_tag, act[k], expv[k], act[k].st, expv[k].st);
        end
      end
  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, a, e);
    end
  endtask
  function automatic vec_t outs(state_t s, logic r, logic t, logic [6:0] o, logic tr, logic be);
    vec_t v;
    v = '0;
    v.st = s;
    v.trap = tr;
    v.berr = be;
    case (s)
      S_FETCH:    begin v.req = 1; v.sb = 2; v.rs = 2; v.irw = r; v.pcw = r; end
      S_DECODE:   begin v.sa = 1; v.sb = 1; v.imm = 2; end
      S_MEMADR:   begin v.sa = 2; v.sb = 1; v.imm = (o == 7'b0100011) ? 3'd1 : 3'd0; end
      S_MEMREAD:  begin v.req = 1; v.adr = 1; end
      S_MEMWB:    begin v.rs = 1; v.rw = 1; end
      S_MEMWRITE: begin v.req = 1; v.mw = 1; v.adr = 1; end
      S_EXECR:    begin v.sa = 2; v.aop = 2; end
      S_EXECI:    begin v.sa = 2; v.sb = 1; v.aop = 2; end
      S_ALUWB:    v.rw = 1;
      S_BRANCH:   begin v.sa = 2; v.aop = 1; v.pcw = t; end
      S_JAL:      begin v.sa = 1; v.sb = 2; v.pcw = 1; end
      S_JALR:     begin v.sa = 2; v.sb = 1; end
      S_JALRPC:   begin v.sa = 1; v.sb = 2; v.pcw = 1; end
      S_LUI:      begin v.imm = 4; v.rs = 3; v.rw = 1; end
      S_AUIPC:    begin v.sa = 1; v.sb = 1; v.imm = 4; end
      default:    ;
    endcase
    return v;
  endfunction
  // States an instruction visits after DECODE; instance 0 traps on illegal and has lui/auipc, instance 1 does neither.
  function automatic sq_t route(int k, logic [6:0] o, logic [2:0] f);
    sq_t q;
    q = {};
    case (o)
      7'b0000011: q = {S_MEMADR, S_MEMREAD, S_MEMWB};
      7'b0100011: q = {S_MEMADR, S_MEMWRITE};
      7'b0110011: q = {S_EXECR, S_ALUWB};
      7'b0010011: q = {S_EXECI, S_ALUWB};
      7'b1100011: begin
        q = {S_BRANCH};
        if (f[2:1] == 2'b01 && k == 0) q.push_back(S_TRAP);
      end
      7'b1101111: q = {S_JAL, S_ALUWB};
      7'b1100111: q = {S_JALR, S_JALRPC, S_ALUWB};
      7'b0110111: if (k == 0) q = {S_LUI}; else q = {};
      7'b0010111: if (k == 0) q = {S_AUIPC, S_ALUWB}; else q = {};
      default: if (k == 0) q = {S_TRAP};
    endcase
    return q;
  endfunction
  task automatic step(input int k, input state_t s, input logic r, input logic t, input logic tr,
                      input logic be, input logic to, input string tag);
    rdy[k] = r;
    chk = '0;
    chk[k] = 1'b1;
    cur_tag = tag;
    expv[k] = outs(s, r, t, op[k], tr, be);
    if (to) {expv[k].pcw, expv[k].req, expv[k].mw, expv[k].irw, expv[k].rw} = '0;
    @(negedge clk);
    obs.push_back(act[k]);
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input int k, input logic [6:0] o, input logic [2:0] f, input logic t,
                       input int fw, input int mw, input string tag);
    sq_t p, r;
    op[k] = o;
    f3[k] = f;
    obs.delete();
    p = {S_FETCH, S_DECODE};
    r = route(k, o, f);
    foreach (r[i]) p.push_back(r[i]);
    foreach (p[i]) begin
      int w;
      w = p[i] == S_FETCH ? fw : (p[i] == S_MEMREAD || p[i] == S_MEMWRITE) ? mw : p[i] == S_TRAP ? 19 : 0;
      for (int j = 0; j <= w; j++)
        step(k, p[i], p[i] == S_TRAP || j == w, t, p[i] == S_TRAP, 1'b0, 1'b0, tag);
    end
  endtask
  task automatic do_reset(input int k);
    chk = '0;
    rst[k] = 1'b1;
    @(posedge clk);
    #1;
    rst[k] = 1'b0;
  endtask
  task automatic set_flags(input int k, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    zero[k] = diff == 0;
    r31[k] = diff[31];
    cy[k] = a < b;
  endtask
  br_t br [12] = '{
    '{3'b000, 32'd5, 32'd5, 1'b1}, '{3'b000, 32'd5, 32'd6, 1'b0},
    '{3'b001, 32'd5, 32'd6, 1'b1}, '{3'b001, 32'd7, 32'd7, 1'b0},
    '{3'b100, 32'hFFFFFFFD, 32'd2, 1'b1}, '{3'b100, 32'd4, 32'd2, 1'b0},
    '{3'b101, 32'd4, 32'd2, 1'b1}, '{3'b101, 32'hFFFFFFFF, 32'd0, 1'b0},
    '{3'b110, 32'd1, 32'd2, 1'b1}, '{3'b110, 32'hFFFFFFFF, 32'd1, 1'b0},
    '{3'b111, 32'hFFFFFFFF, 32'd1, 1'b1}, '{3'b111, 32'd0, 32'd1, 1'b0}
  };
  initial begin
    int n;
    rst = 2'b11;
    chk = '0;
    rdy = 2'b11;
    zero = '0;
    r31 = '0;
    cy = '0;
    op[0] = '0;
    op[1] = '0;
    f3[0] = '0;
    f3[1] = '0;
    @(posedge clk);
    #1;
    check("rst_state", act[0].st, S_FETCH);
    check("rst_strobes", {act[0].pcw, act[0].req, act[0].mw, act[0].irw, act[0].rw}, 0);
    check("rst_flags", {act[0].trap, act[0].berr}, 0);
    rst = 2'b00;
    instr(0, 7'b0000011, 3'b010, 1'b0, 0, 2, "lw_wait");
    n = 0;
    foreach (obs[i]) n += int'(obs[i].rw);
    check("lw_cycles", obs.size(), 7);
    check("lw_regwrite_count", n, 1);
    check("lw_regwrite_in_mwb", obs[6].rw, 1);
    check("lw_path", {obs[2].st, obs[3].st, obs[5].st, obs[6].st}, {S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMWB});
    instr(0, 7'b1101111, 3'b000, 1'b0, 0, 0, "jal");
    check("jal_seq", {obs[0].st, obs[1].st, obs[2].st, obs[3].st}, {S_FETCH, S_DECODE, S_JAL, S_ALUWB});
    check("jal_pcw_rw", {obs[2].pcw, obs[3].rw, obs[2].rs, obs[3].rs}, 6'b110000);
    instr(0, 7'b0110011, 3'b000, 1'b0, 1, 0, "rtype");
    instr(0, 7'b0010011, 3'b101, 1'b0, 0, 0, "itype");
    instr(0, 7'b0100011, 3'b010, 1'b0, 0, 1, "sw");
    instr(0, 7'b1100111, 3'b000, 1'b0, 0, 0, "jalr");
    instr(0, 7'b0110111, 3'b000, 1'b0, 0, 0, "lui");
    check("lui_resultsrc", obs[2].rs, 2'b11);
    instr(0, 7'b0010111, 3'b000, 1'b0, 0, 0, "auipc");
    foreach (br[i]) begin
      set_flags(0, br[i].a, br[i].b);
      instr(0, 7'b1100011, br[i].f, br[i].t, 0, 0, "branch");
      check("branch_taken", obs[2].pcw, br[i].t);
    end
    zero[0] = 1'b1;
    instr(0, 7'b1100011, 3'b010, 1'b0, 0, 0, "branch_bad_f3");
    check("branch_bad_trap", {obs[2].pcw, obs[3].trap}, 2'b01);
    do_reset(0);
    instr(0, 7'b1111111, 3'b000, 1'b0, 0, 0, "illegal_trap");
    n = 0;
    for (int i = 2; i < obs.size(); i++) n += int'(obs[i].pcw | obs[i].req | obs[i].mw | obs[i].irw | obs[i].rw);
    check("illegal_trap_next", obs[2].trap, 1);
    check("illegal_trap_len", obs.size(), 22);
    check("illegal_trap_strobes", n, 0);
    do_reset(0);
    op[0] = 7'b0100011;
    obs.delete();
    step(0, S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sw_rst");
    step(0, S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sw_rst");
    step(0, S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sw_rst");
    step(0, S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sw_rst");
    chk = '0;
    #1;
    check("pre_rst_memwrite", {act[0].mw, act[0].req}, 2'b11);
    rst[0] = 1'b1;
    #1;
    check("rst_drop_memwrite", act[0].mw, 0);
    check("rst_drop_mem_req", act[0].req, 0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    check("post_rst_state", act[0].st, S_FETCH);
    check("post_rst_flags", {act[0].trap, act[0].berr}, 0);
    instr(0, 7'b0110011, 3'b000, 1'b0, 0, 0, "after_rst");
    do_reset(1);
    instr(1, 7'b1111111, 3'b000, 1'b0, 0, 0, "illegal_nop");
    check("illegal_nop_len", obs.size(), 2);
    instr(1, 7'b0110011, 3'b000, 1'b0, 0, 0, "after_nop");
    instr(1, 7'b0110111, 3'b000, 1'b0, 0, 0, "lui_absent");
    zero[1] = 1'b0;
    instr(1, 7'b1100011, 3'b011, 1'b0, 0, 0, "branch_bad_nop");
    instr(1, 7'b0000011, 3'b010, 1'b0, 0, 3, "lw_short_wait");
    op[1] = 7'b0000011;
    obs.delete();
    for (int i = 0; i < 4; i++) step(1, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "timeout_wait");
    step(1, S_FETCH, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "timeout_hit");
    for (int i = 0; i < 3; i++) step(1, S_TRAP, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "timeout_trap");
    n = 0;
    foreach (obs[i]) n += int'(obs[i].irw);
    check("timeout_irwrite_never", n, 0);
    check("timeout_flags_wait4", {obs[3].berr, obs[3].trap}, 2'b00);
    check("timeout_flags_after4", {obs[4].berr, obs[4].trap}, 2'b11);
    do_reset(1);
    step(1, S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "timeout_cleared");
    chk = '0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
